ad7864_emu: RTL and testbench

- Synthesizable responder that emulates the AD7864 4-channel, 12-bit ADC as seen from the CPLD's ADC driver pins (ADC_CONV, AD_CS, ADC_RD, ADC_DB).
- Sits on the far end of the driver-to-ADC interface and serves two purposes: board self-test with no ADC fitted, and a bit-exact counterpart for driver regression.
- Produces deterministic per-channel sample patterns, plus BUSY/EOC timing that follows the AD7864 sequence.

---
 rtl/ad7864_pkg.sv | 19 +
 rtl/ad7864_sync_edge.sv | 43 ++++
 rtl/ad7864_emu.sv | 176 +++++++++++++++++
 tb/tb_ad7864_emu.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad7864_pkg.sv
// Shared AD7864 types: FSM state, channel index, sample word and the
// {channel, frame} pattern builder used by the driver and the emulator.
package ad7864_pkg;

    localparam int unsigned SAMPLE_W = 12;

    typedef enum logic [0:0] {
        IDLE,
        CONVERT
    } state_t;

    typedef logic [1:0]          ch_t;
    typedef logic [SAMPLE_W-1:0] sample_t;

    function automatic sample_t make_sample(input ch_t ch, input logic [SAMPLE_W-3:0] frame);
        return {ch, frame};
    endfunction

endpackage

// File: rtl/ad7864_sync_edge.sv
// Multi-stage synchronizer (STAGES >= 2) with registered rise/fall pulses
// that are aligned with the cycle in which the level output changes.
module ad7864_sync_edge #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;

    // Edges are taken one stage early so the pulse coincides with the final
    // stage changing, keeping pin-to-pulse latency at STAGES cycles.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        rise_d = sync_q[STAGES-2] & ~sync_q[STAGES-1];
        fall_d = ~sync_q[STAGES-2] & sync_q[STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/ad7864_emu.sv
// AD7864 responder: BUSY/EOC conversion sequence and double-buffered
// {channel, frame} samples. Define AD7864_EMU_OVERRUN_EN for ADC_OVERRUN.
module ad7864_emu
    import ad7864_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DATA_W      = 12,
    parameter int unsigned CONV_CYCLES = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              CLOCKPIN,
    input  logic              RST,
    input  logic              ADC_CONV,
    input  logic              ADC_CS_N,
    input  logic              ADC_RD_N,
    output logic              ADC_BUSY,
    output logic              ADC_EOC_N,
    output logic [DATA_W-1:0] ADC_DB,
    output logic              ADC_DB_OE
`ifdef AD7864_EMU_OVERRUN_EN
    ,
    output logic              ADC_OVERRUN
`endif
);

    localparam int unsigned CNT_W   = $clog2(CONV_CYCLES);
    localparam int unsigned FRAME_W = DATA_W - 2;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CONV_CYCLES - 1);
    localparam ch_t LAST_CH = ch_t'(NUM_CH - 1);

    logic conv_level, conv_rise, conv_fall;
    logic cs_level, cs_rise, cs_fall;
    logic rd_level, rd_rise, rd_fall;
    logic unused_sync;

    ad7864_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_conv (
        .clk(CLOCKPIN), .rst(RST), .d(ADC_CONV),
        .level(conv_level), .rise(conv_rise), .fall(conv_fall)
    );
    ad7864_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(CLOCKPIN), .rst(RST), .d(ADC_CS_N),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );
    ad7864_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_rd (
        .clk(CLOCKPIN), .rst(RST), .d(ADC_RD_N),
        .level(rd_level), .rise(rd_rise), .fall(rd_fall)
    );

    assign unused_sync = ^{conv_level, conv_fall, cs_rise, cs_fall, rd_level, rd_fall};

    state_t                         state_q, state_d;
    ch_t                            ch_q, ch_d;
    ch_t                            ptr_q, ptr_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [FRAME_W-1:0]             frame_q, frame_d;
    logic [NUM_CH-1:0][DATA_W-1:0]  work_q, work_d;
    logic [NUM_CH-1:0][DATA_W-1:0]  read_q, read_d;
    logic                           busy_q, busy_d;
    logic                           eoc_n_q, eoc_n_d;
    logic [DATA_W-1:0]              db_q, db_d;
    logic                           frame_done;
`ifdef AD7864_EMU_OVERRUN_EN
    localparam int unsigned RDC_W = $clog2(NUM_CH + 1);
    logic [RDC_W-1:0]               rd_cnt_q, rd_cnt_d;
    logic                           have_frame_q, have_frame_d;
    logic                           ovr_q, ovr_d;
`endif

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        cnt_d      = cnt_q;
        frame_d    = frame_q;
        work_d     = work_q;
        read_d     = read_q;
        busy_d     = busy_q;
        ptr_d      = ptr_q;
        frame_done = 1'b0;

        case (state_q)
            IDLE: begin
                if (conv_rise) begin
                    state_d = CONVERT;
                    ch_d    = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            CONVERT: begin
                if (cnt_q == LAST_CNT) begin
                    work_d[ch_q] = make_sample(ch_q, frame_q);
                    cnt_d        = '0;
                    ch_d         = ch_q + ch_t'(1);
                    if (ch_q == LAST_CH) begin
                        // Publish includes the sample captured this same cycle.
                        state_d    = IDLE;
                        busy_d     = 1'b0;
                        frame_done = 1'b1;
                        read_d     = work_d;
                        frame_d    = frame_q + FRAME_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (frame_done) begin
            ptr_d = '0;
        end else if (rd_rise && !cs_level) begin
            ptr_d = (ptr_q == LAST_CH) ? '0 : ptr_q + ch_t'(1);
        end

        eoc_n_d = !((state_d == CONVERT) && (cnt_d == LAST_CNT));
        db_d    = read_q[ptr_q];

`ifdef AD7864_EMU_OVERRUN_EN
        rd_cnt_d     = rd_cnt_q;
        have_frame_d = have_frame_q | frame_done;
        ovr_d        = ovr_q;
        if (conv_rise && state_q == CONVERT) ovr_d = 1'b1;
        if (frame_done && have_frame_q && rd_cnt_q < RDC_W'(NUM_CH)) ovr_d = 1'b1;
        if (frame_done) begin
            rd_cnt_d = '0;
        end else if (rd_rise && !cs_level && rd_cnt_q < RDC_W'(NUM_CH)) begin
            rd_cnt_d = rd_cnt_q + RDC_W'(1);
        end
`endif
    end

    always_ff @(posedge CLOCKPIN or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            ch_q    <= '0;
            cnt_q   <= '0;
            frame_q <= '0;
            work_q  <= '0;
            read_q  <= '0;
            busy_q  <= 1'b0;
            eoc_n_q <= 1'b1;
            db_q    <= '0;
            ptr_q   <= '0;
`ifdef AD7864_EMU_OVERRUN_EN
            rd_cnt_q     <= '0;
            have_frame_q <= 1'b0;
            ovr_q        <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            work_q  <= work_d;
            read_q  <= read_d;
            busy_q  <= busy_d;
            eoc_n_q <= eoc_n_d;
            db_q    <= db_d;
            ptr_q   <= ptr_d;
`ifdef AD7864_EMU_OVERRUN_EN
            rd_cnt_q     <= rd_cnt_d;
            have_frame_q <= have_frame_d;
            ovr_q        <= ovr_d;
`endif
        end
    end

    assign ADC_BUSY  = busy_q;
    assign ADC_EOC_N = eoc_n_q;
    assign ADC_DB    = db_q;
    assign ADC_DB_OE = ~ADC_CS_N & ~ADC_RD_N;
`ifdef AD7864_EMU_OVERRUN_EN
    assign ADC_OVERRUN = ovr_q;
`endif

endmodule

// File: tb/tb_ad7864_emu.sv
// Self-checking bench for ad7864_emu against a frame-level reference model
// (bank contents, read pointer, overrun flag) with randomized read/convert traffic.
module tb_ad7864_emu;

    logic        clk  = 1'b0;
    logic        rst  = 1'b0;
    logic        conv = 1'b0;
    logic        cs_n = 1'b1;
    logic        rd_n = 1'b1;
    logic        busy, eoc_n, db_oe;
    logic [11:0] db;
`ifdef AD7864_EMU_OVERRUN_EN
    logic        ovr;
`endif

    int errors = 0;
    int checks = 0;

    int m_frame, m_ptr, m_reads;
    int m_bank[4];
    bit m_have, m_ovr;

    always #5 clk = ~clk;

    ad7864_emu #(
        .NUM_CH(4),
        .DATA_W(12),
        .CONV_CYCLES(8),
        .SYNC_STAGES(2)
    ) dut (
        .CLOCKPIN(clk),
        .RST(rst),
        .ADC_CONV(conv),
        .ADC_CS_N(cs_n),
        .ADC_RD_N(rd_n),
        .ADC_BUSY(busy),
        .ADC_EOC_N(eoc_n),
        .ADC_DB(db),
        .ADC_DB_OE(db_oe)
`ifdef AD7864_EMU_OVERRUN_EN
        ,
        .ADC_OVERRUN(ovr)
`endif
    );

    function automatic int exp_sample(input int ch, input int frame);
        return (ch * 1024) + (frame % 1024);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_frame = 0;
        m_ptr   = 0;
        m_reads = 0;
        m_have  = 1'b0;
        m_ovr   = 1'b0;
        for (int i = 0; i < 4; i++) m_bank[i] = 0;
    endtask

    task automatic model_complete();
        if (m_have && m_reads < 4) m_ovr = 1'b1;
        for (int c = 0; c < 4; c++) m_bank[c] = exp_sample(c, m_frame);
        m_frame++;
        m_ptr   = 0;
        m_reads = 0;
        m_have  = 1'b1;
    endtask

    task automatic wait_busy(input logic lvl, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (busy === lvl) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic read_one(input string name);
        cs_n = 1'b0;
        rd_n = 1'b0;
        repeat (4 + $urandom_range(0, 3)) tick();
        checks++;
        if (db_oe !== 1'b1 || db !== 12'(m_bank[m_ptr])) begin
            errors++;
            $display("FAIL %s: db=%h oe=%b, expected db=%h oe=1", name, db, db_oe, 12'(m_bank[m_ptr]));
        end
        rd_n = 1'b1;
        repeat (4) tick();
        m_ptr = (m_ptr + 1) % 4;
        m_reads++;
        cs_n = 1'b1;
        repeat ($urandom_range(2, 4)) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        model_reset();
        tick();
        checks++;
        if (busy !== 1'b0 || eoc_n !== 1'b1 || db !== 12'h000 || db_oe !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b eoc_n=%b db=%h oe=%b, expected 0 1 000 0", busy, eoc_n, db, db_oe);
        end
`ifdef AD7864_EMU_OVERRUN_EN
        checks++;
        if (ovr !== 1'b0) begin
            errors++;
            $display("FAIL reset_overrun: got %b expected 0", ovr);
        end
`endif
    endtask

    task automatic test_conversion();
        int          lat, b;
        logic [63:0] eoc_mask, exp_mask;
        lat = 0;
        conv = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 1) conv = 1'b0;
            if (busy === 1'b1) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL busy_latency: got %0d cycles expected 3", lat);
        end
        b        = 0;
        eoc_mask = '0;
        while (busy === 1'b1 && b < 60) begin
            b++;
            if (eoc_n === 1'b0) eoc_mask[b] = 1'b1;
            tick();
        end
        checks++;
        if (b != 32) begin
            errors++;
            $display("FAIL busy_width: got %0d expected 32", b);
        end
        exp_mask = '0;
        exp_mask[8]  = 1'b1;
        exp_mask[16] = 1'b1;
        exp_mask[24] = 1'b1;
        exp_mask[32] = 1'b1;
        checks++;
        if (eoc_mask !== exp_mask || eoc_n !== 1'b1) begin
            errors++;
            $display("FAIL eoc_pulses: got mask=%h eoc_after=%b expected mask=%h eoc_after=1", eoc_mask, eoc_n, exp_mask);
        end
        model_complete();
    endtask

    task automatic test_read_frame0();
        for (int i = 0; i < 5; i++) read_one("frame0_read");
        checks++;
        if (db_oe !== 1'b0) begin
            errors++;
            $display("FAIL oe_idle: got %b expected 0", db_oe);
        end
    endtask

    task automatic test_read_during_busy();
        bit ok;
        conv = 1'b1;
        tick();
        conv = 1'b0;
        wait_busy(1'b1, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL busy_rise_timeout: busy=%b expected 1", busy);
        end
        read_one("busy_read_old");
        read_one("busy_read_old");
        wait_busy(1'b0, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL busy_fall_timeout: busy=%b expected 0", busy);
        end
        model_complete();
        repeat (2) tick();
        for (int i = 0; i < 4; i++) read_one("frame1_read");
    endtask

    task automatic test_conv_while_busy();
        bit ok, rose;
        int b;
        conv = 1'b1;
        tick();
        conv = 1'b0;
        wait_busy(1'b1, ok);
        b = 0;
        while (busy === 1'b1 && b < 60) begin
            b++;
            if (b == 10) conv = 1'b1;
            if (b == 11) conv = 1'b0;
            tick();
        end
        checks++;
        if (ok !== 1'b1 || b != 32) begin
            errors++;
            $display("FAIL conv_busy_width: got %0d (started=%b) expected 32", b, ok);
        end
        m_ovr = 1'b1;
        model_complete();
        rose = 1'b0;
        repeat (40) begin
            tick();
            if (busy !== 1'b0) rose = 1'b1;
        end
        checks++;
        if (rose !== 1'b0) begin
            errors++;
            $display("FAIL conv_busy_no_second: busy rose=%b expected 0", rose);
        end
`ifdef AD7864_EMU_OVERRUN_EN
        checks++;
        if (ovr !== 1'b1) begin
            errors++;
            $display("FAIL overrun_conv_busy: got %b expected 1", ovr);
        end
`endif
        read_one("after_conv_busy");
    endtask

    task automatic test_rd_cs_high();
        bit oe_bad;
        oe_bad = 1'b0;
        cs_n   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_n = 1'b0;
            repeat (4) begin
                tick();
                if (db_oe !== 1'b0) oe_bad = 1'b1;
            end
            rd_n = 1'b1;
            repeat (4) begin
                tick();
                if (db_oe !== 1'b0) oe_bad = 1'b1;
            end
        end
        checks++;
        if (oe_bad !== 1'b0) begin
            errors++;
            $display("FAIL cs_high_oe: oe seen=%b expected 0", oe_bad);
        end
        read_one("cs_high_ptr_hold");
    endtask

    task automatic test_rd_at_completion();
        bit ok;
        cs_n = 1'b0;
        rd_n = 1'b0;
        tick();
        conv = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (k == 1) conv = 1'b0;
        end
        rd_n = 1'b1;
        wait_busy(1'b0, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL rd_completion_timeout: busy=%b expected 0", busy);
        end
        repeat (4) tick();
        cs_n = 1'b1;
        model_complete();
        repeat (2) tick();
        read_one("rd_at_completion_ptr0");
        read_one("rd_at_completion_next");
    endtask

    task automatic test_reset_mid_conv();
        bit ok;
        conv = 1'b1;
        tick();
        conv = 1'b0;
        wait_busy(1'b1, ok);
        repeat (19) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (ok !== 1'b1 || busy !== 1'b0 || db !== 12'h000 || eoc_n !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: started=%b busy=%b db=%h eoc_n=%b expected 1 0 000 1", ok, busy, db, eoc_n);
        end
`ifdef AD7864_EMU_OVERRUN_EN
        checks++;
        if (ovr !== 1'b0) begin
            errors++;
            $display("FAIL reset_clears_overrun: got %b expected 0", ovr);
        end
`endif
        tick();
        rst = 1'b0;
        model_reset();
        tick();
        conv = 1'b1;
        tick();
        conv = 1'b0;
        wait_busy(1'b1, ok);
        wait_busy(1'b0, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_conv_timeout: busy=%b expected 0", busy);
        end
        model_complete();
        repeat (2) tick();
        for (int i = 0; i < 4; i++) read_one("post_reset_frame0");
    endtask

    task automatic test_random();
        bit ok;
        for (int it = 0; it < 8; it++) begin
            repeat ($urandom_range(0, 5)) read_one("random_read");
            conv = 1'b1;
            repeat ($urandom_range(1, 3)) tick();
            conv = 1'b0;
            wait_busy(1'b1, ok);
            wait_busy(1'b0, ok);
            checks++;
            if (ok !== 1'b1) begin
                errors++;
                $display("FAIL random_conv_timeout: iter=%0d busy=%b expected 0", it, busy);
                break;
            end
            model_complete();
            tick();
`ifdef AD7864_EMU_OVERRUN_EN
            checks++;
            if (ovr !== m_ovr) begin
                errors++;
                $display("FAIL random_overrun: iter=%0d got %b expected %b", it, ovr, m_ovr);
            end
`endif
        end
        for (int i = 0; i < 4; i++) read_one("random_final_read");
    endtask

    task automatic test_frame_wrap();
        bit ok;
        while (m_frame < 1025) begin
            conv = 1'b1;
            tick();
            conv = 1'b0;
            wait_busy(1'b1, ok);
            if (ok) wait_busy(1'b0, ok);
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL wrap_conv_timeout: frame=%0d busy=%b", m_frame, busy);
                break;
            end
            model_complete();
            tick();
        end
        repeat (2) tick();
        for (int i = 0; i < 4; i++) read_one("frame_wrap_read");
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_conversion();
        test_read_frame0();
        test_read_during_busy();
        test_conv_while_busy();
        test_rd_cs_high();
        test_rd_at_completion();
        test_reset_mid_conv();
        test_random();
        test_frame_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
